// File: rtl/svc_axil_arb_pkg.sv
// Shared types and constants for the AXI-lite read arbiter.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: AXI response codes, arbiter FSM state type, grant-index width helper.
package svc_axil_arb_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  // Width of a manager index; a single-bit index is kept even for NUM_M == 1.
  function automatic int grant_idx_w(input int num_m);
    return (num_m > 1) ? $clog2(num_m) : 1;
  endfunction

endpackage

// File: rtl/svc_rr_arbiter.sv
// Purpose: pick one requester; round-robin from last_grant+1, or lowest index
//          when SVC_AXIL_RD_ARB_FIXED_PRIO_EN is defined.
// Latency: purely combinational. Backpressure: none, caller decides when to accept.
// Ports: req (request vector), last_grant (previous winner index),
//        grant_oh (one-hot winner), grant_idx (winner index), any_vld (some request).
module svc_rr_arbiter
  import svc_axil_arb_pkg::*;
#(
  parameter  int NUM_M = 2,
  localparam int GW    = grant_idx_w(NUM_M)
) (
  input  logic [NUM_M-1:0] req,
  input  logic [GW-1:0]    last_grant,
  output logic [NUM_M-1:0] grant_oh,
  output logic [GW-1:0]    grant_idx,
  output logic             any_vld
);

`ifdef SVC_AXIL_RD_ARB_FIXED_PRIO_EN
  // Fixed priority ignores history.
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;

  always_comb begin
    grant_idx = '0;
    // Walk downward so the lowest set index is the last one written.
    for (int k = NUM_M - 1; k >= 0; k--) begin
      if (req[k]) grant_idx = GW'(k);
    end
  end
`else
  int   cand;
  logic found;

  always_comb begin
    grant_idx = '0;
    cand      = 0;
    found     = 1'b0;
    // Offsets 1..NUM_M visit every manager once, starting just after the
    // previous winner; offset NUM_M re-visits the previous winner last.
    for (int k = 1; k <= NUM_M; k++) begin
      cand = (int'(last_grant) + k) % NUM_M;
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = GW'(cand);
      end
    end
  end
`endif

  assign any_vld  = |req;
  assign grant_oh = any_vld ? (NUM_M'(1) << grant_idx) : '0;

endmodule

// File: rtl/svc_axil_rd_arbiter.sv
// Purpose: share one AXI-lite read subordinate among NUM_M read managers, one
//          transaction outstanding; R beat routed back to the granted manager.
// Latency: s AR handshake in N -> m_axil_arvalid in N+1; >= 3 cycles/transaction.
// Backpressure: arready only in IDLE; m_axil_rready follows the granted manager's rready.
// Ports: clk, rst_n (async active-low); s_axil_* manager-side AR/R (packed per manager,
//        manager i at slice i); m_axil_* subordinate-side AR/R.
// Build option: SVC_AXIL_RD_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module svc_axil_rd_arbiter
  import svc_axil_arb_pkg::*;
#(
  parameter int NUM_M = 2,
  parameter int AW    = 20,
  parameter int DW    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_M-1:0]    s_axil_arvalid,
  input  logic [NUM_M*AW-1:0] s_axil_araddr,
  output logic [NUM_M-1:0]    s_axil_arready,
  output logic [NUM_M-1:0]    s_axil_rvalid,
  output logic [NUM_M*DW-1:0] s_axil_rdata,
  output logic [NUM_M*2-1:0]  s_axil_rresp,
  input  logic [NUM_M-1:0]    s_axil_rready,
  output logic                m_axil_arvalid,
  output logic [AW-1:0]       m_axil_araddr,
  input  logic                m_axil_arready,
  input  logic                m_axil_rvalid,
  input  logic [DW-1:0]       m_axil_rdata,
  input  logic [1:0]          m_axil_rresp,
  output logic                m_axil_rready
);

  localparam int GW = grant_idx_w(NUM_M);

  arb_state_e       state;
  arb_state_e       state_nxt;
  logic [GW-1:0]    gnt_q;
  logic [GW-1:0]    last_grant;
  logic [NUM_M-1:0] req_oh;
  logic [GW-1:0]    req_idx;
  logic             req_any;
  logic             ar_accept;
  logic             r_done;

  svc_rr_arbiter #(.NUM_M(NUM_M)) u_arb (
    .req       (s_axil_arvalid),
    .last_grant(last_grant),
    .grant_oh  (req_oh),
    .grant_idx (req_idx),
    .any_vld   (req_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Every handshake output is decoded from registered state plus the arbiter;
  // m_axil_arvalid depends on state alone, so no s valid reaches m valid.
  always_comb begin
    state_nxt      = state;
    s_axil_arready = '0;
    s_axil_rvalid  = '0;
    m_axil_arvalid = 1'b0;
    m_axil_rready  = 1'b0;
    ar_accept      = 1'b0;
    r_done         = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // The winner is chosen among asserted arvalid bits, so raising its
        // arready completes the handshake this cycle.
        if (req_any) begin
          s_axil_arready = req_oh;
          ar_accept      = 1'b1;
          state_nxt      = ST_ADDR;
        end
      end
      ST_ADDR: begin
        m_axil_arvalid = 1'b1;
        if (m_axil_arready) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (m_axil_rvalid) s_axil_rvalid = NUM_M'(1) << gnt_q;
        m_axil_rready = s_axil_rready[gnt_q];
        if (m_axil_rvalid && s_axil_rready[gnt_q]) begin
          r_done    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q         <= '0;
      last_grant    <= GW'(NUM_M - 1);
      m_axil_araddr <= '0;
    end else begin
      if (ar_accept) begin
        gnt_q         <= req_idx;
        m_axil_araddr <= s_axil_araddr[int'(req_idx)*AW +: AW];
      end
      // Rotation advances only on completion, so a reset-discarded
      // transaction does not count as served.
      if (r_done) last_grant <= gnt_q;
    end
  end

  // Only the granted manager sees rvalid, so replicating data is harmless.
  assign s_axil_rdata = {NUM_M{m_axil_rdata}};
  assign s_axil_rresp = {NUM_M{m_axil_rresp}};

endmodule

// File: tb/tb_svc_axil_rd_arbiter.sv
module tb_svc_axil_rd_arbiter;
  import svc_axil_arb_pkg::*;

  localparam int NUM_M = 2;
  localparam int AW    = 20;
  localparam int DW    = 16;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NUM_M-1:0]    s_arvalid, s_arready, s_rvalid, s_rready;
  logic [NUM_M*AW-1:0] s_araddr;
  logic [NUM_M*DW-1:0] s_rdata;
  logic [NUM_M*2-1:0]  s_rresp;
  logic                m_arvalid, m_arready, m_rvalid, m_rready;
  logic [AW-1:0]       m_araddr;
  logic [DW-1:0]       m_rdata;
  logic [1:0]          m_rresp;

  svc_axil_rd_arbiter #(.NUM_M(NUM_M), .AW(AW), .DW(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axil_arvalid(s_arvalid),
    .s_axil_araddr (s_araddr),
    .s_axil_arready(s_arready),
    .s_axil_rvalid (s_rvalid),
    .s_axil_rdata  (s_rdata),
    .s_axil_rresp  (s_rresp),
    .s_axil_rready (s_rready),
    .m_axil_arvalid(m_arvalid),
    .m_axil_araddr (m_araddr),
    .m_axil_arready(m_arready),
    .m_axil_rvalid (m_rvalid),
    .m_axil_rdata  (m_rdata),
    .m_axil_rresp  (m_rresp),
    .m_axil_rready (m_rready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- stimulus knobs ----------------
  int            pend[NUM_M];
  logic [AW-1:0] addr_k[NUM_M];
  int            rhold[NUM_M];
  int            ar_wait;
  logic [DW-1:0] sub_rdata;
  logic [1:0]    sub_rresp;
  int            sub_phase, sub_cnt;

  // ---------------- reference model ----------------
  bit               busy, ar_done;
  int               owner, exp_last, cyc, g;
  logic [AW-1:0]    exp_addr, ar_addr_seen;
  int               recv_cnt[NUM_M];
  logic [DW-1:0]    recv_data[NUM_M];
  logic [1:0]       recv_resp[NUM_M];
  int               grant_log[$];
  int               grant_cyc[$];
  int               ar_stall, r_stall;
  logic [NUM_M-1:0] e_ar_rdy, e_rv, ar_hs_vec;
  bit               e_mrr, m_ar_hs, m_r_hs;

  // Who should win, given the set of requesters and the previous winner.
  function automatic int pick(input logic [NUM_M-1:0] v, input int last);
`ifdef SVC_AXIL_RD_ARB_FIXED_PRIO_EN
    for (int c = 0; c < NUM_M; c++) if (v[c]) return c;
`else
    for (int off = 1; off <= NUM_M; off++) begin
      int c;
      c = (last + off) % NUM_M;
      if (v[c]) return c;
    end
`endif
    return -1;
  endfunction

  // Compare process: sample away from the rising edge, then advance the model
  // with the handshakes that the coming edge will complete.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_m_arvalid", m_arvalid, 0);
      chk("rst_m_araddr",  m_araddr,  0);
      chk("rst_s_arready", s_arready, 0);
      chk("rst_s_rvalid",  s_rvalid,  0);
      chk("rst_m_rready",  m_rready,  0);
      busy = 0; ar_done = 0; exp_last = NUM_M - 1;
      ar_hs_vec = '0; m_ar_hs = 0; m_r_hs = 0;
    end else begin
      e_ar_rdy = '0;
      if (!busy && s_arvalid != '0) e_ar_rdy[pick(s_arvalid, exp_last)] = 1'b1;
      e_rv  = (busy && ar_done && m_rvalid) ? (NUM_M'(1) << owner) : '0;
      e_mrr = busy && ar_done && s_rready[owner];
      chk("m_arvalid", m_arvalid, busy && !ar_done);
      if (busy && !ar_done) chk("m_araddr", m_araddr, exp_addr);
      chk("s_arready", s_arready, e_ar_rdy);
      chk("s_rvalid",  s_rvalid,  e_rv);
      chk("m_rready",  m_rready,  e_mrr);
      if (e_rv != '0) begin
        chk("s_rdata", s_rdata[owner*DW +: DW], m_rdata);
        chk("s_rresp", s_rresp[owner*2 +: 2],   m_rresp);
      end
      if (busy && !ar_done && !m_arready) ar_stall++;
      if (e_rv != '0 && !e_mrr) r_stall++;

      ar_hs_vec = s_arvalid & s_arready;
      m_ar_hs   = m_arvalid && m_arready;
      m_r_hs    = m_rvalid && m_rready;

      if (e_ar_rdy != '0) begin
        g        = pick(s_arvalid, exp_last);
        busy     = 1; ar_done = 0; owner = g;
        exp_addr = s_araddr[g*AW +: AW];
        grant_log.push_back(g);
        grant_cyc.push_back(cyc);
      end else if (busy && !ar_done && m_arready) begin
        ar_done      = 1;
        ar_addr_seen = m_araddr;
      end else if (busy && ar_done && m_rvalid && s_rready[owner]) begin
        recv_cnt[owner]++;
        recv_data[owner] = s_rdata[owner*DW +: DW];
        recv_resp[owner] = s_rresp[owner*2 +: 2];
        exp_last = owner;
        busy     = 0;
      end
    end
  end

  // Managers and subordinate, driven just after each rising edge.
  initial begin
    s_arvalid = '0; s_araddr = '0; s_rready = '1;
    m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = '0;
    sub_phase = 0; sub_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        sub_phase = 0; sub_cnt = 0; m_arready = 0; m_rvalid = 0;
        s_arvalid = '0; s_rready = '1;
        continue;
      end
      for (int i = 0; i < NUM_M; i++) begin
        if (ar_hs_vec[i] && pend[i] > 0) pend[i]--;
        if (m_rvalid && rhold[i] > 0) rhold[i]--;
      end
      if (sub_phase == 3 && m_r_hs) begin m_rvalid = 0; sub_phase = 0; sub_cnt = 0; end
      if (sub_phase == 1 && m_ar_hs) begin m_arready = 0; sub_phase = 2; end
      if (sub_phase == 2) begin
        m_rvalid = 1; m_rdata = sub_rdata; m_rresp = sub_rresp; sub_phase = 3;
      end
      if (sub_phase == 0) begin
        m_arready = 0;
        if (m_arvalid) begin
          if (sub_cnt >= ar_wait) begin m_arready = 1; sub_phase = 1; end
          else sub_cnt++;
        end
      end
      for (int i = 0; i < NUM_M; i++) begin
        s_arvalid[i]             = (pend[i] > 0);
        s_araddr[i*AW +: AW]     = addr_k[i];
        s_rready[i]              = (rhold[i] == 0);
      end
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic wait_recv(input int m, input int target, input string name);
    for (int i = 0; i < 300 && recv_cnt[m] < target; i++) step();
    chk(name, recv_cnt[m], target);
  endtask

  task automatic chk_order(input string name, input int exp_q[$]);
    chk({name, "_len"}, grant_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk(name, (i < grant_log.size()) ? grant_log[i] : -1, exp_q[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  int base0, base1;
  int exp_q[$];

  initial begin
    for (int i = 0; i < NUM_M; i++) begin
      pend[i] = 0; addr_k[i] = '0; rhold[i] = 0; recv_cnt[i] = 0;
    end
    ar_wait = 0; sub_rdata = '0; sub_rresp = RESP_OKAY;
    exp_last = NUM_M - 1;

    // 1. reset
    rst_n = 0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1;
    step();
    chk("idle_arready",  s_arready, 0);
    chk("idle_rvalid",   s_rvalid,  0);
    chk("idle_m_arvalid", m_arvalid, 0);

    // 2. single read by manager 1
    addr_k[0] = 20'h0B000; addr_k[1] = 20'h0A000;
    sub_rdata = 16'hD000; sub_rresp = RESP_OKAY;
    pend[1] = 1;
    wait_recv(1, 1, "single_done");
    chk("single_rdata", recv_data[1], 16'hD000);
    chk("single_rresp", recv_resp[1], 0);
    chk("single_araddr", ar_addr_seen, 20'h0A000);
    chk("single_m0_idle", recv_cnt[0], 0);

    // 3. contention
    grant_log.delete(); grant_cyc.delete();
    sub_rdata = 16'h1234;
`ifdef SVC_AXIL_RD_ARB_FIXED_PRIO_EN
    pend[0] = 4; pend[1] = 1;
    wait_recv(1, 2, "fixed_done");
    exp_q = '{0, 0, 0, 0, 1};
    chk_order("fixed_order", exp_q);
`else
    pend[0] = 2; pend[1] = 2;
    wait_recv(1, 3, "rr_done");
    exp_q = '{0, 1, 0, 1};
    chk_order("rr_order", exp_q);
`endif
    chk("txn_period", (grant_cyc.size() > 1) ? grant_cyc[1] - grant_cyc[0] : -1, 3);

    // 4. backpressure: 3 cycles of arready low, then 2 cycles of rready low
    base0 = recv_cnt[0]; base1 = recv_cnt[1];
    grant_log.delete(); ar_stall = 0; r_stall = 0;
    ar_wait = 3; rhold[0] = 2; sub_rdata = 16'h4444;
    pend[0] = 1; pend[1] = 1;
    wait_recv(1, base1 + 1, "bp_m1_done");
    chk("bp_m0_once", recv_cnt[0], base0 + 1);
    chk("bp_rdata", recv_data[0], 16'h4444);
    chk("bp_ar_stall", ar_stall, 6);
    chk("bp_r_stall", r_stall, 2);
    exp_q = '{0, 1};
    chk_order("bp_order", exp_q);

    // 5. error responses pass through
    ar_wait = 0; base0 = recv_cnt[0]; base1 = recv_cnt[1];
    sub_rdata = 16'hEEEE; sub_rresp = RESP_SLVERR;
    pend[0] = 1;
    wait_recv(0, base0 + 1, "slverr_done");
    chk("slverr_resp", recv_resp[0], 2'b10);
    chk("slverr_rdata", recv_data[0], 16'hEEEE);
    sub_rresp = RESP_DECERR;
    pend[0] = 1;
    wait_recv(0, base0 + 2, "decerr_done");
    chk("decerr_resp", recv_resp[0], 2'b11);
    chk("err_m1_untouched", recv_cnt[1], base1);

    // 6. reset while in ADDR; manager 0 must win afterwards
    sub_rresp = RESP_OKAY; ar_wait = 20; base1 = recv_cnt[1];
    pend[1] = 1;
    for (int i = 0; i < 20 && !m_arvalid; i++) step();
    chk("pre_rst_arvalid", m_arvalid, 1);
    #1 rst_n = 0;
    #1 chk("rst_drops_arvalid", m_arvalid, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    ar_wait = 0; grant_log.delete();
    base0 = recv_cnt[0];
    pend[0] = 1; pend[1] = 1;
    wait_recv(1, base1 + 1, "post_rst_m1_done");
    chk("post_rst_m0_done", recv_cnt[0], base0 + 1);
    exp_q = '{0, 1};
    chk_order("post_rst_order", exp_q);

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
